// File: rtl/md_tester_pkg.sv
// -----------------------------------------------------------------------------
// md_tester_pkg
// Shared definitions for the adder-pipeline tester: FSM state encoding,
// sweep size, default pipeline latency and the reference result function.
// -----------------------------------------------------------------------------
package md_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned NUM_VEC     = 8;
    localparam int unsigned LATENCY_DEF = 2;

    // Reference result for vector {A,B,D}: A + B + D, wrapped to 2 bits.
    function automatic logic [1:0] exp_sum(input logic [2:0] v);
        return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

endpackage

// File: rtl/md_delay_line.sv
// -----------------------------------------------------------------------------
// md_delay_line
// LATENCY-deep shift register of {valid, 2-bit expected result}, asynchronously
// cleared. Stage 0 loads every cycle; the tail lines up with the pipeline output.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high clear
//   valid_i   : entry valid for this cycle
//   data_i    : expected result for this cycle
//   valid_o   : tail entry valid
//   data_o    : tail entry expected result
// -----------------------------------------------------------------------------
module md_delay_line #(
    parameter int unsigned LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [1:0] data_i,
    output logic       valid_o,
    output logic [1:0] data_o
);

    logic [2:0] stage_q [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            // Invalid entries carry zero data so the line never holds stale results.
            stage_q[0] <= valid_i ? {1'b1, data_i} : 3'b000;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign valid_o = stage_q[LATENCY-1][2];
    assign data_o  = stage_q[LATENCY-1][1:0];

endmodule

// File: rtl/md_pipeline_tester.sv
// -----------------------------------------------------------------------------
// md_pipeline_tester
// Stimulus driver and checker for the two-stage adder pipeline
// (E = (A + B) + D, plus combinational A0 pass-through). A start request
// sweeps all 8 {A,B,D} vectors, checks each E against a delayed prediction
// and A0 in the same cycle, and reports a saturating error count and pass flag.
//   clk         : rising-edge clock shared with the pipeline
//   rst         : asynchronous active-high reset
//   IN_START    : level-sampled start request (only honoured in IDLE)
//   IN_E        : pipeline OUT_E
//   IN_A0       : pipeline OUT_A0
//   OUT_A/B/D   : registered stimulus to pipeline IN_A/IN_B/IN_D
//   OUT_BUSY    : high while driving or draining
//   OUT_DONE    : one-cycle pulse at end of a run
//   OUT_PASS    : last completed run had zero errors
//   OUT_ERR_CNT : mismatch cycle count of current/last run
// -----------------------------------------------------------------------------
module md_pipeline_tester
    import md_tester_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LATENCY = LATENCY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_START,
    input  logic [1:0]       IN_E,
    input  logic             IN_A0,
    output logic             OUT_A,
    output logic             OUT_B,
    output logic             OUT_D,
    output logic             OUT_BUSY,
    output logic             OUT_DONE,
    output logic             OUT_PASS,
    output logic [CNT_W-1:0] OUT_ERR_CNT
);

    localparam int unsigned DRN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state_q, state_d;
    logic [2:0]         vec_q, vec_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic               pass_q, pass_d;
    logic               tail_valid;
    logic [1:0]         tail_exp;
    logic               mismatch;

    md_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .valid_i (state_q == ST_DRIVE),
        .data_i  (exp_sum(vec_q)),
        .valid_o (tail_valid),
        .data_o  (tail_exp)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        drn_d   = '0;
        pass_d  = pass_q;
        err_d   = err_q;

        mismatch = (tail_valid && (IN_E != tail_exp)) ||
                   ((state_q == ST_DRIVE) && (IN_A0 != vec_q[2]));
        if (mismatch && (err_q != '1)) begin
            err_d = err_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (IN_START) begin
                    state_d = ST_DRIVE;
                    vec_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_DRIVE: begin
                // vec_q wraps 7 -> 0, so stimulus returns to zero for DRAIN.
                vec_d = vec_q + 3'd1;
                if (vec_q == 3'(NUM_VEC - 1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drn_q == DRN_W'(LATENCY - 1)) begin
                    state_d = ST_DONE;
                    // Uses err_d: the final E compare lands in this last DRAIN cycle.
                    pass_d  = (err_d == '0);
                end else begin
                    drn_d = drn_q + DRN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            drn_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            drn_q   <= drn_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign OUT_A       = vec_q[2];
    assign OUT_B       = vec_q[1];
    assign OUT_D       = vec_q[0];
    assign OUT_BUSY    = (state_q == ST_DRIVE) || (state_q == ST_DRAIN);
    assign OUT_DONE    = (state_q == ST_DONE);
    assign OUT_PASS    = pass_q;
    assign OUT_ERR_CNT = err_q;

endmodule

// File: tb/tb_md_pipeline_tester.sv
// -----------------------------------------------------------------------------
// tb_md_pipeline_tester
// Directed bench: a behavioural adder pipeline (correct, E stuck at 0, A0
// stuck at 0, or single-register) feeds the tester; a second instance with a
// 2-bit counter sees E tied to 0.
// -----------------------------------------------------------------------------
module tb_md_pipeline_tester;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start2;
    logic [1:0] in_e;
    logic       in_a0;
    logic       a, b, d, busy, done, pass;
    logic [7:0] err;
    logic       a2, b2, d2, busy2, done2, pass2;
    logic [1:0] err2;

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;   // 0 correct, 1 E stuck 0, 2 A0 stuck 0, 3 single register

    always #5 clk = ~clk;

    md_pipeline_tester #(.CNT_W(8), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .IN_START(start), .IN_E(in_e), .IN_A0(in_a0),
        .OUT_A(a), .OUT_B(b), .OUT_D(d), .OUT_BUSY(busy), .OUT_DONE(done),
        .OUT_PASS(pass), .OUT_ERR_CNT(err)
    );

    md_pipeline_tester #(.CNT_W(2), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .IN_START(start2), .IN_E(2'b00), .IN_A0(a2),
        .OUT_A(a2), .OUT_B(b2), .OUT_D(d2), .OUT_BUSY(busy2), .OUT_DONE(done2),
        .OUT_PASS(pass2), .OUT_ERR_CNT(err2)
    );

    // Behavioural pipeline under test (no reset).
    logic [1:0] p_s1, p_e2, p_single;
    logic       p_d1;
    always @(posedge clk) begin
        p_s1     <= {1'b0, a} + {1'b0, b};
        p_d1     <= d;
        p_e2     <= p_s1 + {1'b0, p_d1};
        p_single <= {1'b0, a} + {1'b0, b} + {1'b0, d};
    end
    assign in_e  = (mode == 1) ? 2'b00 : (mode == 3) ? p_single : p_e2;
    assign in_a0 = (mode == 2) ? 1'b0 : a;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Pulse IN_START and follow the run cycle by cycle; restart_cyc re-pulses start mid-run.
    task automatic run(input string tag, input int exp_err, input int exp_pass, input int restart_cyc);
        bit seen = 0;
        int dcyc = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;          // negedge of cycle 1
        for (int c = 1; c <= 14 && !seen; c++) begin
            if (c == restart_cyc)     start = 1'b1;
            if (c == restart_cyc + 1) start = 1'b0;
            if (c <= 11) check_eq({tag, "_busy"}, busy, (c <= 10) ? 1 : 0);
            if (c <= 8)       check_eq({tag, "_vec"}, {a, b, d}, c - 1);
            else if (c <= 11) check_eq({tag, "_vec_idle"}, {a, b, d}, 0);
            if (done) begin
                seen = 1;
                dcyc = c;
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        check_eq({tag, "_done_seen"}, seen, 1);
        check_eq({tag, "_done_cycle"}, dcyc, 11);
        check_eq({tag, "_err"}, err, exp_err);
        check_eq({tag, "_pass"}, pass, exp_pass);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_err_hold"}, err, exp_err);
        check_eq({tag, "_pass_hold"}, pass, exp_pass);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_err",  err,  0);
        check_eq("rst_abd",  {a, b, d}, 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        mode = 0; run("good", 0, 1, -10);
        mode = 1; run("e_stuck", 7, 0, -10);
        mode = 2; run("a0_stuck", 4, 0, -10);
        mode = 3; run("single_reg", 6, 0, -10);
        mode = 0; run("restart_ignored", 0, 1, 5);

        // Saturation on the 2-bit counter instance.
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;          // cycle 1
        repeat (7) @(negedge clk);              // cycle 8: 4 mismatches counted
        check_eq("sat_mid", err2, 3);
        repeat (3) @(negedge clk);              // cycle 11
        check_eq("sat_done", done2, 1);
        check_eq("sat_err", err2, 3);
        check_eq("sat_pass", pass2, 0);

        // Reset mid-run with E stuck at 0.
        mode = 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;           // cycle 1
        repeat (5) @(negedge clk);              // cycle 6
        check_eq("pre_rst_err", err, 2);
        check_eq("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_err", err, 0);
        check_eq("mid_rst_abd", {a, b, d}, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_pass", pass, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_err", err, 0);
        mode = 0; run("fresh", 0, 1, -10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
